bitty_mem_responder: RTL and testbench
======================================

// Module: bitty_mem_responder
// PURPOSE
//  Far end of the Bitty CPU's UART load/store link: decodes the byte requests the CPU LSU transmits,
//  backs them with a DEPTH x 16-bit word memory, and answers loads with two data bytes.
//  Sits between the host-side UART receiver/transmitter and a local memory array.
//  Stores are silent (no reply); loads reply hi byte then lo byte.
// PARAMETERS
//  DEPTH   256   words of memory; power of two, 2..256
//  AW      8     memory index width = log2(DEPTH)
//  INIT_W  16'h0 reset value of every memory word
// PORTS
//  clk        in   1   system clock, rising edge
//  reset      in   1   asynchronous, active-high reset
//  rx_data    in   8   byte received from the CPU's UART transmitter
//  rx_done    in   1   1-cycle strobe: rx_data valid this cycle
//  tx_done    in   1   1-cycle strobe: local UART finished sending the last byte
//  tx_en      out  1   1-cycle strobe: start sending tx_data
//  tx_data    out  8   byte to send to the CPU; held stable from tx_en until tx_done
//  pre_we     in   1   bench/host preload write enable (ignored unless state IDLE)
//  pre_addr   in   AW  preload word index
//  pre_wdata  in   16  preload word
//  busy       out  1   1 whenever state != IDLE
//  req_cnt    out  16  completed requests (load reply fully sent, or store written); wraps at 16'hFFFF
// BEHAVIOUR
//  Reset: tx_en=0, tx_data=8'h00, busy=0, req_cnt=0, state=IDLE, all memory words=INIT_W.
//  Request framing (byte order on rx): LOAD = 8'h4C, addr; STORE = 8'h53, addr, data_hi, data_lo.
//  addr is 8 bits; word index = addr[AW-1:0] (upper bits ignored, i.e. wraps modulo DEPTH).
//  FSM states and transitions (all on rx_done/tx_done strobes, one transition per cycle):
//   IDLE    : rx_done & byte==4C -> ADDR_L; byte==53 -> ADDR_S; other byte -> stay (dropped, see CONFIG)
//   ADDR_L  : rx_done -> latch addr, read word -> SEND_HI
//   ADDR_S  : rx_done -> latch addr -> DATA_HI
//   DATA_HI : rx_done -> latch hi -> DATA_LO
//   DATA_LO : rx_done -> mem[idx] <= {hi,rx_data} on the same edge, req_cnt++ -> IDLE
//   SEND_HI : assert tx_en 1 cycle, tx_data=word[15:8] -> WAIT_HI
//   WAIT_HI : tx_done -> SEND_LO
//   SEND_LO : tx_en 1 cycle, tx_data=word[7:0] -> WAIT_LO
//   WAIT_LO : tx_done -> req_cnt++ -> IDLE
//  Latency: tx_en for hi byte rises 1 cycle after the addr rx_done edge; lo tx_en 1 cycle after hi tx_done.
//  Read value is captured in ADDR_L (snapshot); a later preload cannot alter an in-flight reply.
//  rx_done while in SEND_*/WAIT_* (half-duplex violation): byte dropped, FSM unaffected.
//  tx_done in any state other than WAIT_*: ignored.
//  Simultaneous rx_done and tx_done: each consumed only by the state that expects it.
//  pre_we in IDLE writes mem[pre_addr] next edge; if rx_done arrives same cycle, preload still wins
//  (stores never complete in IDLE so no write conflict). pre_we outside IDLE is ignored.
//  Reset mid-request: frame abandoned, outputs to reset values, memory reinitialised to INIT_W.
//  Store to addr then immediate load of addr returns the stored word (write precedes read by >=2 bytes).
// CONFIGURATION
//  BITTY_RESP_ERR_EN defined: unknown opcode byte in IDLE -> reply single byte 8'hEE
//   (tx_en 1 cycle after rx_done, wait tx_done, back to IDLE); output err_cnt[7:0] counts these,
//   saturates at 8'hFF, reset 0. req_cnt not incremented for error replies.
//  Not defined: unknown opcode silently dropped, no reply, no err_cnt port.
// TESTING
//  Preload mem[5]=16'hBEEF; rx 4C,05 -> tx_en pulses with tx_data=BE then (after tx_done) EF; req_cnt=1.
//  rx 53,12,CA,FE then 4C,12 -> reply CA,FE; req_cnt=2; busy low between requests.
//  DEPTH=16: rx 53,13,12,34 then 4C,03 -> reply 12,34 (address wrap to index 3).
//  Assert reset after 53,20,AA -> busy=0, tx_en=0; then 4C,20 -> reply 00,00 (INIT_W), store lost.
//  During WAIT_HI inject rx_done(53) and stray tx_done in IDLE -> reply completes normally, no extra tx_en.
//  With BITTY_RESP_ERR_EN: rx 7F -> tx_data=EE once, err_cnt=1, req_cnt unchanged; without: no tx_en.

Source files
------------

// File: rtl/bitty_mem_responder.sv
// Bitty UART load/store responder: byte-framed requests backed by a word memory.
// Define BITTY_RESP_ERR_EN to reply 8'hEE to unknown opcodes and expose err_cnt.
module bitty_mem_responder #(
  parameter int          DEPTH  = 256,
  parameter int          AW     = 8,
  parameter logic [15:0] INIT_W = 16'h0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_done,
  input  logic          tx_done,
  output logic          tx_en,
  output logic [7:0]    tx_data,
  input  logic          pre_we,
  input  logic [AW-1:0] pre_addr,
  input  logic [15:0]   pre_wdata,
  output logic          busy,
`ifdef BITTY_RESP_ERR_EN
  output logic [7:0]    err_cnt,
`endif
  output logic [15:0]   req_cnt
);

  localparam logic [7:0] OP_LD = 8'h4C;
  localparam logic [7:0] OP_ST = 8'h53;

  typedef enum logic [3:0] {
    IDLE, ADDR_L, ADDR_S, DATA_HI, DATA_LO,
    SEND_HI, WAIT_HI, SEND_LO, WAIT_LO,
    SEND_ERR, WAIT_ERR
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   idx_q;
  logic [7:0]      hi_q;
  logic [7:0]      lo_q;
  logic            tx_en_q;
  logic [7:0]      tx_data_q;
  logic [15:0]     req_cnt_q;
  logic [15:0]     mem_q [DEPTH];

  logic            wr_en_d;
  logic [AW-1:0]   wr_idx_d;
  logic [15:0]     wr_data_d;
  logic [15:0]     rd_word;

  assign rd_word = mem_q[rx_data[AW-1:0]];

  // Preload and store writes are exclusive by state, so one port suffices.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_idx_d  = pre_addr;
    wr_data_d = pre_wdata;
    if (state_q == IDLE && pre_we) begin
      wr_en_d = 1'b1;
    end else if (state_q == DATA_LO && rx_done) begin
      wr_en_d   = 1'b1;
      wr_idx_d  = idx_q;
      wr_data_d = {hi_q, rx_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= INIT_W;
    end else if (wr_en_d) begin
      mem_q[wr_idx_d] <= wr_data_d;
    end
  end

`ifdef BITTY_RESP_ERR_EN
  logic [7:0] err_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      hi_q      <= 8'h00;
      lo_q      <= 8'h00;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
      req_cnt_q <= 16'h0000;
`ifdef BITTY_RESP_ERR_EN
      err_cnt_q <= 8'h00;
`endif
    end else begin
      tx_en_q <= 1'b0;
      unique case (state_q)
        IDLE: if (rx_done) begin
          if (rx_data == OP_LD) state_q <= ADDR_L;
          else if (rx_data == OP_ST) state_q <= ADDR_S;
`ifdef BITTY_RESP_ERR_EN
          else begin
            tx_en_q   <= 1'b1;
            tx_data_q <= 8'hEE;
            state_q   <= SEND_ERR;
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
          end
`endif
        end
        // Word snapshot taken here; later preloads cannot alter the reply.
        ADDR_L: if (rx_done) begin
          lo_q      <= rd_word[7:0];
          tx_en_q   <= 1'b1;
          tx_data_q <= rd_word[15:8];
          state_q   <= SEND_HI;
        end
        ADDR_S: if (rx_done) begin
          idx_q   <= rx_data[AW-1:0];
          state_q <= DATA_HI;
        end
        DATA_HI: if (rx_done) begin
          hi_q    <= rx_data;
          state_q <= DATA_LO;
        end
        DATA_LO: if (rx_done) begin
          req_cnt_q <= req_cnt_q + 16'd1;
          state_q   <= IDLE;
        end
        SEND_HI: state_q <= WAIT_HI;
        WAIT_HI: if (tx_done) begin
          tx_en_q   <= 1'b1;
          tx_data_q <= lo_q;
          state_q   <= SEND_LO;
        end
        SEND_LO: state_q <= WAIT_LO;
        WAIT_LO: if (tx_done) begin
          req_cnt_q <= req_cnt_q + 16'd1;
          state_q   <= IDLE;
        end
        SEND_ERR: state_q <= WAIT_ERR;
        WAIT_ERR: if (tx_done) state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  assign tx_en   = tx_en_q;
  assign tx_data = tx_data_q;
  assign busy    = (state_q != IDLE);
  assign req_cnt = req_cnt_q;

endmodule

// File: tb/tb_bitty_mem_responder.sv
// Directed bench for bitty_mem_responder: DEPTH=256 and DEPTH=16 instances
// share one request stream and are checked against hand-derived replies.
module tb_bitty_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        tx_done;
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [15:0] pre_wdata;

  logic        tx_en, tx_en16;
  logic [7:0]  tx_data, tx_data16;
  logic        busy, busy16;
  logic [15:0] req_cnt, req_cnt16;
`ifdef BITTY_RESP_ERR_EN
  logic [7:0]  err_cnt, err_cnt16;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bitty_mem_responder #(.DEPTH(256), .AW(8)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_done(rx_done), .tx_done(tx_done),
    .tx_en(tx_en), .tx_data(tx_data),
    .pre_we(pre_we), .pre_addr(pre_addr), .pre_wdata(pre_wdata),
    .busy(busy),
`ifdef BITTY_RESP_ERR_EN
    .err_cnt(err_cnt),
`endif
    .req_cnt(req_cnt)
  );

  bitty_mem_responder #(.DEPTH(16), .AW(4)) dut16 (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_done(rx_done), .tx_done(tx_done),
    .tx_en(tx_en16), .tx_data(tx_data16),
    .pre_we(pre_we), .pre_addr(pre_addr[3:0]), .pre_wdata(pre_wdata),
    .busy(busy16),
`ifdef BITTY_RESP_ERR_EN
    .err_cnt(err_cnt16),
`endif
    .req_cnt(req_cnt16)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic rx(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  // Expect a tx_en pulse on the first cycle, then ack it with tx_done.
  task automatic get_tx(input string tag, input logic [7:0] e,
                        input logic [7:0] e16, input bit inj);
    int n = 0;
    bit got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (tx_en) got = 1'b1;
    end
    chk({tag, "_en"}, 32'(got), 1);
    chk({tag, "_lat"}, n, 1);
    chk({tag, "_en16"}, 32'(tx_en16), 1);
    chk({tag, "_d"}, 32'(tx_data), 32'(e));
    chk({tag, "_d16"}, 32'(tx_data16), 32'(e16));
    @(posedge clk); #1;
    if (inj) rx(8'h53);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(tx_en | tx_en16), 0);
    chk({tag, "_hold"}, 32'(tx_data), 32'(e));
    @(posedge clk); #1;
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
  endtask

  task automatic no_tx(input string tag, input int cycles);
    int c = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (tx_en || tx_en16) c++;
    end
    chk(tag, c, 0);
    @(posedge clk); #1;
  endtask

  task automatic load(input string tag, input logic [7:0] a,
                      input logic [15:0] w, input logic [15:0] w16);
    rx(8'h4C);
    rx(a);
    get_tx({tag, "_hi"}, w[15:8], w16[15:8], 1'b0);
    get_tx({tag, "_lo"}, w[7:0], w16[7:0], 1'b0);
  endtask

  task automatic store(input logic [7:0] a, input logic [15:0] w);
    rx(8'h53);
    rx(a);
    rx(w[15:8]);
    rx(w[7:0]);
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] w);
    pre_addr  = a;
    pre_wdata = w;
    pre_we    = 1'b1;
    @(posedge clk); #1;
    pre_we    = 1'b0;
  endtask

  task automatic idle_chk(input string tag, input logic [15:0] rc);
    @(negedge clk);
    chk({tag, "_busy"}, 32'(busy | busy16), 0);
    chk({tag, "_req"}, 32'(req_cnt), 32'(rc));
    chk({tag, "_req16"}, 32'(req_cnt16), 32'(rc));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rx_data = 8'h00; rx_done = 1'b0; tx_done = 1'b0;
    pre_we = 1'b0; pre_addr = 8'h00; pre_wdata = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_txen", 32'(tx_en), 0);
    chk("rst_txd", 32'(tx_data), 0);
    chk("rst_req", 32'(req_cnt), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Preloaded load
    preload(8'h05, 16'hBEEF);
    rx(8'h4C);
    @(negedge clk);
    chk("ld_busy", 32'(busy), 1);
    rx(8'h05);
    get_tx("t1_hi", 8'hBE, 8'hBE, 1'b0);
    get_tx("t1_lo", 8'hEF, 8'hEF, 1'b0);
    idle_chk("t1", 16'd1);

    // Store then load back
    store(8'h12, 16'hCAFE);
    idle_chk("t2s", 16'd2);
    load("t2", 8'h12, 16'hCAFE, 16'hCAFE);
    idle_chk("t2l", 16'd3);

    // Snapshot: preload while busy is ignored and cannot alter the reply
    rx(8'h4C);
    rx(8'h05);
    pre_addr = 8'h05; pre_wdata = 16'h1111; pre_we = 1'b1;
    get_tx("t3_hi", 8'hBE, 8'hBE, 1'b0);
    pre_we = 1'b0;
    get_tx("t3_lo", 8'hEF, 8'hEF, 1'b0);
    load("t3b", 8'h05, 16'hBEEF, 16'hBEEF);
    idle_chk("t3", 16'd5);

    // Preload in the same cycle as the opcode byte
    pre_addr = 8'h07; pre_wdata = 16'h7777; pre_we = 1'b1;
    rx(8'h4C);
    pre_we = 1'b0;
    rx(8'h07);
    get_tx("t4_hi", 8'h77, 8'h77, 1'b0);
    get_tx("t4_lo", 8'h77, 8'h77, 1'b0);
    idle_chk("t4", 16'd6);

    // rx during WAIT_HI and stray tx_done in IDLE
    rx(8'h4C);
    rx(8'h12);
    get_tx("t5_hi", 8'hCA, 8'hCA, 1'b1);
    get_tx("t5_lo", 8'hFE, 8'hFE, 1'b0);
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
    no_tx("t5_notx", 5);
    idle_chk("t5", 16'd7);

    // Reset mid-store
    rx(8'h53);
    rx(8'h20);
    rx(8'hAA);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_txen", 32'(tx_en), 0);
    chk("t6_req", 32'(req_cnt), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    load("t6a", 8'h20, 16'h0000, 16'h0000);
    load("t6b", 8'h05, 16'h0000, 16'h0000);
    idle_chk("t6", 16'd2);

    // Address wrap on the 16-deep instance
    store(8'h13, 16'h1234);
    load("t7", 8'h03, 16'h0000, 16'h1234);
    idle_chk("t7", 16'd4);

    // Unknown opcode
    rx(8'h7F);
`ifdef BITTY_RESP_ERR_EN
    get_tx("t8_err", 8'hEE, 8'hEE, 1'b0);
    @(negedge clk);
    chk("t8_errcnt", 32'(err_cnt), 1);
`else
    no_tx("t8_notx", 6);
`endif
    idle_chk("t8", 16'd4);

    load("t9", 8'h13, 16'h1234, 16'h1234);
    idle_chk("t9", 16'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
